anycore_req_queue: RTL and testbench

- Request-side buffer between the AnyCore memory interface and the AnyCore-to-L1.5 decoder.
- Accepts single-cycle i-miss, load and store request pulses into per-class FIFOs, so back-to-back requests are never lost.
- Replays requests to the decoder one at a time as single-cycle valid pulses, priority imiss > load > store.
- Does not issue the next request until the L1.5 acknowledges the current one.

---
 rtl/anycore_req_queue.sv | 246 ++++++++++++++++++++++++
 tb/tb_anycore_req_queue.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anycore_req_queue.sv
// AnyCore request queue: buffers i-miss, load and store request pulses in
// per-class FIFOs and replays them one at a time toward the L1.5 decoder,
// holding back each new request until the previous one is acknowledged.

`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS 26
`endif
`ifndef DCACHE_BLOCK_ADDR_BITS
`define DCACHE_BLOCK_ADDR_BITS 26
`endif
`ifndef DCACHE_ST_ADDR_BITS
`define DCACHE_ST_ADDR_BITS 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

// Small circular FIFO used for each request class. A push into a full
// FIFO is accepted only when the same edge also pops, otherwise it is
// dropped and reported through drop.
module anycore_req_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             nonempty,
   output logic             drop
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             push_ok;

   assign push_ok  = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign nonempty = (count != '0);
   assign head     = mem[rd_ptr];

   // Occupancy after this edge, so the full flag can be registered from it
   always_comb begin
      count_next = count;
      if (push_ok && !pop) begin
         count_next = count + 1'b1;
      end else if (!push_ok && pop) begin
         count_next = count - 1'b1;
      end
   end

   // Pointer, count and full-flag bookkeeping; pointers wrap since depth is a power of 2
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
      end
   end

   // Storage array; contents need no reset because the count gates visibility
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end
endmodule

module anycore_req_queue #(
   parameter int IQ_DEPTH = 2,
   parameter int LQ_DEPTH = 2,
   parameter int SQ_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [`ICACHE_BLOCK_ADDR_BITS-1:0]  anycore_ic2mem_reqaddr,
   input  logic                                anycore_ic2mem_reqvalid,
   input  logic [`DCACHE_BLOCK_ADDR_BITS-1:0]  anycore_dc2mem_ldaddr,
   input  logic                                anycore_dc2mem_ldvalid,
   input  logic [`DCACHE_ST_ADDR_BITS-1:0]     anycore_dc2mem_staddr,
   input  logic [`SIZE_DATA-1:0]               anycore_dc2mem_stdata,
   input  logic [2:0]                          anycore_dc2mem_stsize,
   input  logic                                anycore_dc2mem_stvalid,
   input  logic                                l15_transducer_ack,
   output logic [`ICACHE_BLOCK_ADDR_BITS-1:0]  q_ic2mem_reqaddr,
   output logic                                q_ic2mem_reqvalid,
   output logic [`DCACHE_BLOCK_ADDR_BITS-1:0]  q_dc2mem_ldaddr,
   output logic                                q_dc2mem_ldvalid,
   output logic [`DCACHE_ST_ADDR_BITS-1:0]     q_dc2mem_staddr,
   output logic [`SIZE_DATA-1:0]               q_dc2mem_stdata,
   output logic [2:0]                          q_dc2mem_stsize,
   output logic                                q_dc2mem_stvalid,
   output logic                                iq_full,
   output logic                                lq_full,
   output logic                                sq_full,
   output logic                                overflow,
   output logic                                busy
);
   localparam int IW = `ICACHE_BLOCK_ADDR_BITS;
   localparam int LW = `DCACHE_BLOCK_ADDR_BITS;
   localparam int SAW = `DCACHE_ST_ADDR_BITS;
   localparam int SDW = `SIZE_DATA;
   localparam int SW = SAW + SDW + 3;

   typedef enum logic {
      IDLE,
      WAIT_ACK
   } state_t;

   state_t state;
   state_t state_next;

   logic          sel_ic;
   logic          sel_ld;
   logic          sel_st;
   logic          iq_nonempty;
   logic          lq_nonempty;
   logic          sq_nonempty;
   logic          iq_drop;
   logic          lq_drop;
   logic          sq_drop;
   logic [IW-1:0] iq_head;
   logic [LW-1:0] lq_head;
   logic [SW-1:0] sq_head;
   logic [SW-1:0] sq_din;

   assign sq_din = {anycore_dc2mem_staddr, anycore_dc2mem_stdata, anycore_dc2mem_stsize};

   anycore_req_fifo #(.WIDTH(IW), .DEPTH(IQ_DEPTH)) u_iq (
      .clk      (clk),
      .rst      (rst),
      .push     (anycore_ic2mem_reqvalid),
      .pop      (sel_ic),
      .din      (anycore_ic2mem_reqaddr),
      .head     (iq_head),
      .full     (iq_full),
      .nonempty (iq_nonempty),
      .drop     (iq_drop)
   );

   anycore_req_fifo #(.WIDTH(LW), .DEPTH(LQ_DEPTH)) u_lq (
      .clk      (clk),
      .rst      (rst),
      .push     (anycore_dc2mem_ldvalid),
      .pop      (sel_ld),
      .din      (anycore_dc2mem_ldaddr),
      .head     (lq_head),
      .full     (lq_full),
      .nonempty (lq_nonempty),
      .drop     (lq_drop)
   );

   anycore_req_fifo #(.WIDTH(SW), .DEPTH(SQ_DEPTH)) u_sq (
      .clk      (clk),
      .rst      (rst),
      .push     (anycore_dc2mem_stvalid),
      .pop      (sel_st),
      .din      (sq_din),
      .head     (sq_head),
      .full     (sq_full),
      .nonempty (sq_nonempty),
      .drop     (sq_drop)
   );

   assign busy = (state == WAIT_ACK) || iq_nonempty || lq_nonempty || sq_nonempty;

   // Issue state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Pick the next request (imiss > load > store) when idle or when the current one is acked
   always_comb begin
      state_next = state;
      sel_ic     = 1'b0;
      sel_ld     = 1'b0;
      sel_st     = 1'b0;
      if ((state == IDLE) || l15_transducer_ack) begin
         if (iq_nonempty) begin
            sel_ic = 1'b1;
         end else if (lq_nonempty) begin
            sel_ld = 1'b1;
         end else if (sq_nonempty) begin
            sel_st = 1'b1;
         end
         if (sel_ic || sel_ld || sel_st) begin
            state_next = WAIT_ACK;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // Registered decoder outputs: one-cycle valid pulse, payload held until the next issue
   always_ff @(posedge clk) begin
      if (rst) begin
         q_ic2mem_reqvalid <= 1'b0;
         q_dc2mem_ldvalid  <= 1'b0;
         q_dc2mem_stvalid  <= 1'b0;
         q_ic2mem_reqaddr  <= '0;
         q_dc2mem_ldaddr   <= '0;
         q_dc2mem_staddr   <= '0;
         q_dc2mem_stdata   <= '0;
         q_dc2mem_stsize   <= '0;
         overflow          <= 1'b0;
      end else begin
         q_ic2mem_reqvalid <= sel_ic;
         q_dc2mem_ldvalid  <= sel_ld;
         q_dc2mem_stvalid  <= sel_st;
         if (sel_ic) begin
            q_ic2mem_reqaddr <= iq_head;
         end
         if (sel_ld) begin
            q_dc2mem_ldaddr <= lq_head;
         end
         if (sel_st) begin
            q_dc2mem_staddr <= sq_head[SW-1 -: SAW];
            q_dc2mem_stdata <= sq_head[SDW+2 -: SDW];
            q_dc2mem_stsize <= sq_head[2:0];
         end
         overflow <= overflow || iq_drop || lq_drop || sq_drop;
      end
   end
endmodule

// File: tb/tb_anycore_req_queue.sv
// Self-checking bench for anycore_req_queue: a queue-based reference model
// predicts every output each cycle, and directed scenarios add literal checks.

`ifndef ICACHE_BLOCK_ADDR_BITS
`define ICACHE_BLOCK_ADDR_BITS 26
`endif
`ifndef DCACHE_BLOCK_ADDR_BITS
`define DCACHE_BLOCK_ADDR_BITS 26
`endif
`ifndef DCACHE_ST_ADDR_BITS
`define DCACHE_ST_ADDR_BITS 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_anycore_req_queue;
   localparam int IQ_DEPTH = 2;
   localparam int LQ_DEPTH = 2;
   localparam int SQ_DEPTH = 4;
   localparam int IW = `ICACHE_BLOCK_ADDR_BITS;
   localparam int LW = `DCACHE_BLOCK_ADDR_BITS;
   localparam int SAW = `DCACHE_ST_ADDR_BITS;
   localparam int SDW = `SIZE_DATA;

   typedef struct packed {
      logic [SAW-1:0] addr;
      logic [SDW-1:0] data;
      logic [2:0]     size;
   } st_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [IW-1:0]  ic_addr = '0;
   logic           ic_valid = 1'b0;
   logic [LW-1:0]  ld_addr = '0;
   logic           ld_valid = 1'b0;
   logic [SAW-1:0] st_addr = '0;
   logic [SDW-1:0] st_data = '0;
   logic [2:0]     st_size = '0;
   logic           st_valid = 1'b0;
   logic           ack = 1'b0;

   logic [IW-1:0]  q_ic_addr;
   logic           q_ic_valid;
   logic [LW-1:0]  q_ld_addr;
   logic           q_ld_valid;
   logic [SAW-1:0] q_st_addr;
   logic [SDW-1:0] q_st_data;
   logic [2:0]     q_st_size;
   logic           q_st_valid;
   logic           iq_full;
   logic           lq_full;
   logic           sq_full;
   logic           overflow;
   logic           busy;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   anycore_req_queue #(.IQ_DEPTH(IQ_DEPTH), .LQ_DEPTH(LQ_DEPTH), .SQ_DEPTH(SQ_DEPTH)) dut (
      .clk                     (clk),
      .rst                     (rst),
      .anycore_ic2mem_reqaddr  (ic_addr),
      .anycore_ic2mem_reqvalid (ic_valid),
      .anycore_dc2mem_ldaddr   (ld_addr),
      .anycore_dc2mem_ldvalid  (ld_valid),
      .anycore_dc2mem_staddr   (st_addr),
      .anycore_dc2mem_stdata   (st_data),
      .anycore_dc2mem_stsize   (st_size),
      .anycore_dc2mem_stvalid  (st_valid),
      .l15_transducer_ack      (ack),
      .q_ic2mem_reqaddr        (q_ic_addr),
      .q_ic2mem_reqvalid       (q_ic_valid),
      .q_dc2mem_ldaddr         (q_ld_addr),
      .q_dc2mem_ldvalid        (q_ld_valid),
      .q_dc2mem_staddr         (q_st_addr),
      .q_dc2mem_stdata         (q_st_data),
      .q_dc2mem_stsize         (q_st_size),
      .q_dc2mem_stvalid        (q_st_valid),
      .iq_full                 (iq_full),
      .lq_full                 (lq_full),
      .sq_full                 (sq_full),
      .overflow                (overflow),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   // Reference model state: plain queues plus the expected registered outputs
   logic [IW-1:0]  m_iq[$];
   logic [LW-1:0]  m_lq[$];
   st_t            m_sq[$];
   bit             m_outstanding = 1'b0;
   bit             m_ovf = 1'b0;
   bit             m_iv = 1'b0;
   bit             m_lv = 1'b0;
   bit             m_sv = 1'b0;
   logic [IW-1:0]  m_ic_addr = '0;
   logic [LW-1:0]  m_ld_addr = '0;
   st_t            m_st = '0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model: on each edge, issue from the highest-priority non-empty queue if allowed, then enqueue
   always @(posedge clk) begin
      if (rst) begin
         m_iq.delete();
         m_lq.delete();
         m_sq.delete();
         m_outstanding = 1'b0;
         m_ovf = 1'b0;
         m_iv = 1'b0;
         m_lv = 1'b0;
         m_sv = 1'b0;
         m_ic_addr = '0;
         m_ld_addr = '0;
         m_st = '0;
      end else begin
         m_iv = 1'b0;
         m_lv = 1'b0;
         m_sv = 1'b0;
         if (!m_outstanding || ack) begin
            if (m_iq.size() > 0) begin
               m_ic_addr = m_iq.pop_front();
               m_iv = 1'b1;
            end else if (m_lq.size() > 0) begin
               m_ld_addr = m_lq.pop_front();
               m_lv = 1'b1;
            end else if (m_sq.size() > 0) begin
               m_st = m_sq.pop_front();
               m_sv = 1'b1;
            end
            m_outstanding = m_iv || m_lv || m_sv;
         end
         if (ic_valid) begin
            if (m_iq.size() < IQ_DEPTH) m_iq.push_back(ic_addr);
            else m_ovf = 1'b1;
         end
         if (ld_valid) begin
            if (m_lq.size() < LQ_DEPTH) m_lq.push_back(ld_addr);
            else m_ovf = 1'b1;
         end
         if (st_valid) begin
            if (m_sq.size() < SQ_DEPTH) m_sq.push_back('{st_addr, st_data, st_size});
            else m_ovf = 1'b1;
         end
      end
   end

   // Compare every DUT output against the model in the middle of each cycle
   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("ic_valid", 64'(q_ic_valid), 64'(m_iv));
         checkOutput("ld_valid", 64'(q_ld_valid), 64'(m_lv));
         checkOutput("st_valid", 64'(q_st_valid), 64'(m_sv));
         checkOutput("ic_addr", 64'(q_ic_addr), 64'(m_ic_addr));
         checkOutput("ld_addr", 64'(q_ld_addr), 64'(m_ld_addr));
         checkOutput("st_addr", 64'(q_st_addr), 64'(m_st.addr));
         checkOutput("st_data", 64'(q_st_data), 64'(m_st.data));
         checkOutput("st_size", 64'(q_st_size), 64'(m_st.size));
         checkOutput("iq_full", 64'(iq_full), 64'(m_iq.size() == IQ_DEPTH));
         checkOutput("lq_full", 64'(lq_full), 64'(m_lq.size() == LQ_DEPTH));
         checkOutput("sq_full", 64'(sq_full), 64'(m_sq.size() == SQ_DEPTH));
         checkOutput("overflow", 64'(overflow), 64'(m_ovf));
         checkOutput("busy", 64'(busy),
                     64'(m_outstanding || m_iq.size() > 0 || m_lq.size() > 0 || m_sq.size() > 0));
      end
   end

   // Drive one cycle of inputs across a single rising edge, then return the pulses to idle
   task automatic applyStimulus(input bit icv, input logic [IW-1:0] ica,
                                input bit ldv, input logic [LW-1:0] lda,
                                input bit stv, input logic [SAW-1:0] sta,
                                input logic [SDW-1:0] std, input logic [2:0] sts,
                                input bit ak);
      ic_valid = icv;
      ic_addr  = ica;
      ld_valid = ldv;
      ld_addr  = lda;
      st_valid = stv;
      st_addr  = sta;
      st_data  = std;
      st_size  = sts;
      ack      = ak;
      @(posedge clk);
      #1;
      ic_valid = 1'b0;
      ld_valid = 1'b0;
      st_valid = 1'b0;
      ack      = 1'b0;
   endtask

   task automatic idleCycle(input bit ak);
      applyStimulus(0, '0, 0, '0, 0, '0, '0, '0, ak);
   endtask

   task automatic pushStore(input logic [SAW-1:0] a, input logic [SDW-1:0] d, input logic [2:0] s, input bit ak);
      applyStimulus(0, '0, 0, '0, 1, a, d, s, ak);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      idleCycle(0);
      rst = 1'b0;
   endtask

   initial begin
      idleCycle(0);
      idleCycle(0);
      rst = 1'b0;
      check_en = 1'b1;
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_overflow", 64'(overflow), 64'd0);
      checkOutput("reset_st_valid", 64'(q_st_valid), 64'd0);

      // Single load: pulse two edges after the push, then ack clears busy
      applyStimulus(0, '0, 1, 'h123, 0, '0, '0, '0, 0);
      checkOutput("ld_not_yet", 64'(q_ld_valid), 64'd0);
      idleCycle(0);
      checkOutput("ld_pulse", 64'(q_ld_valid), 64'd1);
      checkOutput("ld_payload", 64'(q_ld_addr), 64'h123);
      idleCycle(0);
      checkOutput("ld_single_pulse", 64'(q_ld_valid), 64'd0);
      checkOutput("ld_payload_held", 64'(q_ld_addr), 64'h123);
      idleCycle(0);
      checkOutput("busy_waiting", 64'(busy), 64'd1);
      idleCycle(1);
      checkOutput("busy_after_ack", 64'(busy), 64'd0);

      // Simultaneous i-miss, load, store: issued in priority order, one per ack
      applyStimulus(1, 'h40, 1, 'h80, 1, 'h10, 'hDEADBEEF, 3'd3, 0);
      idleCycle(0);
      checkOutput("prio_ic", 64'(q_ic_valid), 64'd1);
      checkOutput("prio_ic_addr", 64'(q_ic_addr), 64'h40);
      checkOutput("prio_no_ld", 64'(q_ld_valid), 64'd0);
      idleCycle(0);
      idleCycle(1);
      checkOutput("prio_ld", 64'(q_ld_valid), 64'd1);
      checkOutput("prio_ld_addr", 64'(q_ld_addr), 64'h80);
      idleCycle(1);
      checkOutput("prio_st", 64'(q_st_valid), 64'd1);
      checkOutput("prio_st_addr", 64'(q_st_addr), 64'h10);
      checkOutput("prio_st_data", 64'(q_st_data), 64'hDEADBEEF);
      checkOutput("prio_st_size", 64'(q_st_size), 64'd3);
      idleCycle(1);
      checkOutput("prio_idle", 64'(busy), 64'd0);

      // Back-to-back stores with no ack: first is popped, five fill the FIFO
      resetDut();
      for (int k = 1; k <= 5; k++) begin
         pushStore(SAW'('h100 + k), SDW'('hA000_0000 + k), 3'(k), 0);
         if (k == 4) checkOutput("sq_full_after4", 64'(sq_full), 64'd0);
      end
      checkOutput("sq_full_after5", 64'(sq_full), 64'd1);
      checkOutput("no_ovf_after5", 64'(overflow), 64'd0);

      // Full FIFO with ack-driven pop and push on the same edge: no drop
      pushStore('h106, 'hA000_0006, 3'd6, 1);
      checkOutput("fullpop_st", 64'(q_st_valid), 64'd1);
      checkOutput("fullpop_addr", 64'(q_st_addr), 64'h102);
      checkOutput("fullpop_full", 64'(sq_full), 64'd1);
      checkOutput("fullpop_no_ovf", 64'(overflow), 64'd0);
      pushStore('h107, 'hA000_0007, 3'd7, 0);
      checkOutput("drop_ovf", 64'(overflow), 64'd1);
      for (int k = 0; k < 5; k++) idleCycle(1);
      checkOutput("drain_last_addr", 64'(q_st_addr), 64'h106);
      checkOutput("drain_busy", 64'(busy), 64'd0);

      // Spurious ack in IDLE does nothing
      idleCycle(1);
      checkOutput("spur_st", 64'(q_st_valid), 64'd0);
      checkOutput("spur_busy", 64'(busy), 64'd0);

      // Reset in WAIT_ACK with three queued requests
      resetDut();
      applyStimulus(1, 'h41, 1, 'h81, 1, 'h11, 'h1111, 3'd1, 0);
      applyStimulus(0, '0, 1, 'h82, 0, '0, '0, '0, 0);
      checkOutput("pre_rst_ic", 64'(q_ic_valid), 64'd1);
      resetDut();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_ic_addr", 64'(q_ic_addr), 64'd0);
      checkOutput("rst_ovf", 64'(overflow), 64'd0);
      idleCycle(1);
      idleCycle(0);
      checkOutput("rst_late_ack_ld", 64'(q_ld_valid), 64'd0);
      checkOutput("rst_late_ack_busy", 64'(busy), 64'd0);

      // Pointer wrap: ten stores with continuous ack keep their order
      for (int k = 0; k < 10; k++) begin
         pushStore(SAW'(k), SDW'('h5000 + k), 3'(k), 1);
      end
      idleCycle(1);
      checkOutput("wrap_last_valid", 64'(q_st_valid), 64'd1);
      checkOutput("wrap_last_addr", 64'(q_st_addr), 64'd9);
      checkOutput("wrap_last_data", 64'(q_st_data), 64'h5009);
      idleCycle(1);
      idleCycle(0);
      checkOutput("wrap_busy", 64'(busy), 64'd0);

      check_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
